mem_port_arbiter: RTL and testbench

//  Shares one single-port memory bus between the IF stage (instruction fetch) and the MEM stage (lw/sw).

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory bus between IF and MEM stages,
//               MEM first, with a timeout-protected request/ack sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              bus_cs,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              bus_err
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_IF_ACC  = 2'd1;
    localparam logic [1:0] c_MEM_ACC = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_owner_mem;
    logic               r_bus_cs;
    logic               r_bus_we;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_mem_rdata;
    logic               r_if_ready;
    logic               r_mem_ready;
    logic               r_bus_err;

    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_expire;

    assign w_cnt_next = r_cnt + c_CNT_ONE;
    assign w_expire   = (w_cnt_next == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_owner_mem <= 1'b0;
            r_bus_cs    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (mem_req) begin
                        r_state     <= c_MEM_ACC;
                        r_owner_mem <= 1'b1;
                        r_bus_cs    <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                    end else if (if_req) begin
                        r_state     <= c_IF_ACC;
                        r_owner_mem <= 1'b0;
                        r_bus_cs    <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= '0;
                    end
                end
                c_IF_ACC, c_MEM_ACC: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (bus_ack || w_expire) begin
                        r_state   <= c_RESP;
                        r_bus_cs  <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_bus_err <= ~bus_ack;
                        if (r_owner_mem) begin
                            r_mem_ready <= 1'b1;
                            if (!r_bus_we) begin
                                r_mem_rdata <= bus_ack ? bus_rdata : '0;
                            end
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= bus_ack ? bus_rdata : '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus_cs    = r_bus_cs;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign if_ready  = r_if_ready;
    assign mem_ready = r_mem_ready;
    assign bus_err   = r_bus_err;
    assign if_stall  = if_req & ~r_if_ready;
    assign mem_stall = mem_req & ~r_mem_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with an ack-delay bus model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        if_req    = 1'b0;
    logic [31:0] if_addr   = '0;
    logic        mem_req   = 1'b0;
    logic        mem_we    = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack   = 1'b0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, bus_cs, bus_we, if_stall, mem_stall, bus_err;

    int total = 0;
    int bad   = 0;

    int ack_delay  = 2;
    bit auto_ack   = 1'b1;
    bit manual_ack = 1'b0;
    int resp_cnt   = 0;

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] resp_for(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C01_0004;
        return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
    endfunction

    function automatic exp_t mk(input bit m, input bit c, input bit e, input logic [31:0] d);
        exp_t x;
        x.is_mem = m; x.chk_data = c; x.err = e; x.data = d;
        return x;
    endfunction

    // Bus slave: acks in the ack_delay-th cycle of bus_cs (0 = never).
    always @(negedge clk) begin
        if (!auto_ack) begin
            bus_ack = manual_ack;
        end else if (bus_cs) begin
            resp_cnt++;
            if (ack_delay != 0 && resp_cnt == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = resp_for(bus_addr);
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
            end
        end else begin
            resp_cnt = 0;
            bus_ack  = 1'b0;
        end
    end

    // Scoreboard: every ready pulse retires the oldest expected completion.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        if (!rst && (if_ready || mem_ready)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: if_ready=%0b mem_ready=%0b, required no pulse", if_ready, mem_ready);
            end else begin
                e = exp_q.pop_front();
                if (mem_ready !== e.is_mem || if_ready !== !e.is_mem) begin
                    bad++;
                    $display("FAIL ready_owner: if_ready=%0b mem_ready=%0b, required mem=%0b", if_ready, mem_ready, e.is_mem);
                end
                got = e.is_mem ? mem_rdata : if_rdata;
                total++;
                if (e.chk_data && got !== e.data) begin
                    bad++;
                    $display("FAIL rdata: got %h, required %h", got, e.data);
                end
                total++;
                if (bus_err !== e.err) begin
                    bad++;
                    $display("FAIL bus_err: got %0b, required %0b", bus_err, e.err);
                end
            end
        end else if (!rst && bus_err) begin
            total++;
            bad++;
            $display("FAIL stray_bus_err: got 1 without ready, required 0");
        end
    end

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus_cs, bus_we, if_ready, mem_ready, bus_err} !== 5'b0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: cs=%0b we=%0b ir=%0b mr=%0b err=%0b ird=%h mrd=%h, required all 0",
                     bus_cs, bus_we, if_ready, mem_ready, bus_err, if_rdata, mem_rdata);
        end
        rst = 1'b0;
        ack_delay = 0;
        if_addr = 32'h40; if_req = 1'b1;
        n = 0;
        while (!bus_cs && n < 10) begin @(negedge clk); n++; end
        total++;
        if (bus_cs !== 1'b1) begin
            bad++;
            $display("FAIL reset_cs_rise: bus_cs=%0b, required 1", bus_cs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus_cs !== 1'b0 || if_ready !== 1'b0 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_access: cs=%0b ready=%0b err=%0b, required 0 0 0", bus_cs, if_ready, bus_err);
        end
        repeat (20) @(negedge clk);
        total++;
        if (bus_cs !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: bus_cs=%0b, required 0", bus_cs);
        end
    endtask

    task automatic test_single_fetch();
        int cyc;
        ack_delay = 2;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h8C01_0004));
        if_addr = 32'h40; if_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (!if_ready) begin
                total++;
                if (if_stall !== 1'b1 || (bus_cs && (bus_addr !== 32'h40 || bus_we !== 1'b0))) begin
                    bad++;
                    $display("FAIL fetch_wait: stall=%0b addr=%h we=%0b, required 1 40 0", if_stall, bus_addr, bus_we);
                end
            end
        end while (!if_ready && cyc < 40);
        total++;
        if (cyc !== 3 || if_stall !== 1'b0) begin
            bad++;
            $display("FAIL fetch_latency: cycles=%0d stall=%0b, required 3 0", cyc, if_stall);
        end
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h8C01_0004) begin
            bad++;
            $display("FAIL fetch_pulse: ready=%0b rdata=%h, required 0 8c010004", if_ready, if_rdata);
        end
    endtask

    task automatic test_collision();
        logic [31:0] seen [2];
        int nacc = 0;
        int cyc  = 0;
        bit prev_cs = 1'b0;
        ack_delay = 2;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, resp_for(32'h100)));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h8C01_0004));
        if_addr = 32'h40; if_req = 1'b1;
        mem_addr = 32'h100; mem_we = 1'b0; mem_req = 1'b1;
        do begin
            @(negedge clk); cyc++;
            if (bus_cs && !prev_cs && nacc < 2) begin seen[nacc] = bus_addr; nacc++; end
            prev_cs = bus_cs;
            if (!if_ready) begin
                total++;
                if (if_stall !== 1'b1 || (mem_req && mem_stall !== !mem_ready)) begin
                    bad++;
                    $display("FAIL collide_stall: if_stall=%0b mem_stall=%0b, required 1 %0b", if_stall, mem_stall, !mem_ready);
                end
            end
            if (mem_ready) mem_req = 1'b0;
        end while (!if_ready && cyc < 60);
        if_req = 1'b0;
        total++;
        if (nacc !== 2 || seen[0] !== 32'h100 || seen[1] !== 32'h40) begin
            bad++;
            $display("FAIL collide_order: accesses=%0d first=%h second=%h, required 2 100 40", nacc, seen[0], seen[1]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_store();
        int cyc = 0;
        ack_delay = 3;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0));
        mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_we = 1'b1; mem_req = 1'b1;
        do begin
            @(negedge clk); cyc++;
            if (bus_cs) begin
                total++;
                if (bus_we !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h200) begin
                    bad++;
                    $display("FAIL store_bus: we=%0b wdata=%h addr=%h, required 1 deadbeef 200", bus_we, bus_wdata, bus_addr);
                end
            end
        end while (!mem_ready && cyc < 40);
        mem_req = 1'b0; mem_we = 1'b0;
        total++;
        if (if_rdata !== 32'h8C01_0004 || mem_rdata !== resp_for(32'h100)) begin
            bad++;
            $display("FAIL store_rdata_hold: if_rdata=%h mem_rdata=%h, required 8c010004 %h", if_rdata, mem_rdata, resp_for(32'h100));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc = 0;
        int cs_cycles = 0;
        ack_delay = 0;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 32'h0));
        if_addr = 32'h48; if_req = 1'b1;
        do begin
            @(negedge clk); cyc++;
            if (bus_cs) cs_cycles++;
        end while (!if_ready && cyc < 60);
        if_req = 1'b0;
        total++;
        if (cs_cycles !== 15 || if_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_len: cs_cycles=%0d ready=%0b, required 15 1", cs_cycles, if_ready);
        end
        auto_ack = 1'b0; manual_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus_cs !== 1'b0 || if_ready !== 1'b0 || if_rdata !== 32'h0) begin
                bad++;
                $display("FAIL late_ack: cs=%0b ready=%0b rdata=%h, required 0 0 0", bus_cs, if_ready, if_rdata);
            end
        end
        manual_ack = 1'b0;
        @(negedge clk);
        auto_ack = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int t1 = -1;
        int t2 = -1;
        ack_delay = 2;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, resp_for(32'h40)));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, resp_for(32'h44)));
        if_addr = 32'h40; if_req = 1'b1;
        do begin
            @(negedge clk); cyc++;
            if (if_ready) begin
                if (t1 < 0) begin t1 = cyc; if_addr = 32'h44; end
                else t2 = cyc;
            end
        end while (t2 < 0 && cyc < 60);
        if_req = 1'b0;
        total++;
        if (t1 < 0 || t2 - t1 !== 4) begin
            bad++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, required 4 apart", t1, t2);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_store();
        test_timeout();
        test_back_to_back();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
